// File: rtl/mode_sequencer_if.sv
// Button inputs and mode outputs of mode_sequencer, bundled per block instance.
// Signal prefixes are from the sequencer's point of view.
interface mode_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int MODE_W = 2
);
    logic [NUM_CH-1:0]        i_btn_next;
    logic [NUM_CH-1:0]        i_btn_prev;
    logic                     i_lock;
    logic [NUM_CH*MODE_W-1:0] o_mode;
    logic [NUM_CH-1:0]        o_mode_enable;
    logic [NUM_CH-1:0]        o_changed;

    modport master (
        output i_btn_next, i_btn_prev, i_lock,
        input  o_mode, o_mode_enable, o_changed
    );

    modport slave (
        input  i_btn_next, i_btn_prev, i_lock,
        output o_mode, o_mode_enable, o_changed
    );
endinterface

// File: rtl/mode_sequencer.sv
// Per-channel mode selector: next/prev buttons step the mode with wrap or saturation,
// and a long press on either button returns the channel to DEFAULT_MODE.
module mode_sequencer #(
    parameter int NUM_CH       = 2,
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = 2,
    parameter int WRAP         = 1,
    parameter int HOLD_CYCLES  = 100,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mode_sequencer_if.slave  io_bus
);
    localparam int                 CNT_W       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]   HOLD_C      = CNT_W'(HOLD_CYCLES);
    localparam logic [MODE_W-1:0]  DEF_M       = MODE_W'(DEFAULT_MODE);
    localparam logic [MODE_W-1:0]  LAST_M      = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W:0]    NUM_MODES_W = (MODE_W + 1)'(NUM_MODES);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESS_N, ST_PRESS_P, ST_LONG} state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t             r_state, w_state_nx;
        logic [CNT_W-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
        logic [MODE_W-1:0]  r_mode, w_mode_nx, w_inc, w_dec;
        logic [MODE_W:0]    w_up;
        logic               r_nx_q, r_pv_q, r_changed;
        logic               w_nx, w_pv, w_nx_e, w_pv_e, w_tracked;

        assign w_nx      = io_bus.i_btn_next[c];
        assign w_pv      = io_bus.i_btn_prev[c];
        assign w_nx_e    = w_nx & ~r_nx_q;
        assign w_pv_e    = w_pv & ~r_pv_q;
        assign w_tracked = (r_state == ST_PRESS_N) ? w_nx : w_pv;
        assign w_cnt_inc = r_cnt + 1'b1;

        // One extra bit keeps mode+1 from overflowing when NUM_MODES == 2**MODE_W.
        assign w_up  = {1'b0, r_mode} + 1'b1;
        assign w_inc = (w_up >= NUM_MODES_W) ? ((WRAP != 0) ? '0 : r_mode) : w_up[MODE_W-1:0];
        assign w_dec = (r_mode == '0) ? ((WRAP != 0) ? LAST_M : '0) : r_mode - 1'b1;

        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_mode_nx  = r_mode;
            if (io_bus.i_lock) begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_nx_e && !w_pv_e) begin
                            w_mode_nx  = w_inc;
                            w_state_nx = ST_PRESS_N;
                            w_cnt_nx   = '0;
                        end else if (w_pv_e && !w_nx_e) begin
                            w_mode_nx  = w_dec;
                            w_state_nx = ST_PRESS_P;
                            w_cnt_nx   = '0;
                        end
                    end
                    ST_PRESS_N, ST_PRESS_P: begin
                        if (!w_tracked) begin
                            w_state_nx = ST_IDLE;
                        end else if (w_cnt_inc == HOLD_C) begin
                            w_mode_nx  = DEF_M;
                            w_state_nx = ST_LONG;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end
                    ST_LONG: begin
                        if (!w_nx && !w_pv) w_state_nx = ST_IDLE;
                    end
                    default: w_state_nx = ST_IDLE;
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_mode    <= DEF_M;
                r_nx_q    <= 1'b0;
                r_pv_q    <= 1'b0;
                r_changed <= 1'b0;
            end else begin
                r_state   <= w_state_nx;
                r_cnt     <= w_cnt_nx;
                r_mode    <= w_mode_nx;
                r_nx_q    <= w_nx;
                r_pv_q    <= w_pv;
                r_changed <= (w_mode_nx != r_mode);
            end
        end

        assign io_bus.o_mode[c*MODE_W +: MODE_W] = r_mode;
        assign io_bus.o_mode_enable[c]           = (r_mode != DEF_M);
        assign io_bus.o_changed[c]               = r_changed;
    end
endmodule
